// File: rtl/studio2_keypad_if.sv
// Studio II keypad bundle: PS/2 event in, CPU keypad select in,
// EF scan flags and raw pad masks out.
interface studio2_keypad_if;
  logic [10:0] ps2_key;
  logic        swap;
  logic [3:0]  key_sel;
  logic        ef3;
  logic        ef4;
  logic [9:0]  keys_a;
  logic [9:0]  keys_b;

  modport master (
    output ps2_key, swap, key_sel,
    input  ef3, ef4, keys_a, keys_b
  );

  modport slave (
    input  ps2_key, swap, key_sel,
    output ef3, ef4, keys_a, keys_b
  );
endinterface

// File: rtl/studio2_keypad.sv
// PS/2 key events to the two 10-key Studio II pads, with a per-key
// minimum hold so short taps survive the CPU scan loop.
module studio2_keypad #(
  parameter int HOLD_CYCLES = 500000
) (
  input logic             clk,
  input logic             reset_n,
  studio2_keypad_if.slave kp
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

  logic          tgl_q;
  logic          primed;
  logic          ev;
  logic          press;
  logic [7:0]    code;
  logic [9:0]    hit_a;
  logic [9:0]    hit_b;
  logic [19:0]   hit;
  logic [19:0]   down;
  logic [CW-1:0] cnt [20];
  logic [19:0]   active;
  logic [9:0]    keys_a_q;
  logic [9:0]    keys_b_q;
  logic          ef3_q;
  logic          ef4_q;
  logic [15:0]   sel_3;
  logic [15:0]   sel_4;

  assign code  = kp.ps2_key[7:0];
  assign press = kp.ps2_key[9];
  assign ev    = primed && (kp.ps2_key[10] != tgl_q);
  assign hit   = {hit_b, hit_a};

  // Scancode to pad slot; extended and unmapped codes hit nothing
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    if (!kp.ps2_key[8]) begin
      unique case (code)
        8'h45: hit_a[0] = 1'b1;
        8'h16: hit_a[1] = 1'b1;
        8'h1E: hit_a[2] = 1'b1;
        8'h26: hit_a[3] = 1'b1;
        8'h25: hit_a[4] = 1'b1;
        8'h2E: hit_a[5] = 1'b1;
        8'h36: hit_a[6] = 1'b1;
        8'h3D: hit_a[7] = 1'b1;
        8'h3E: hit_a[8] = 1'b1;
        8'h46: hit_a[9] = 1'b1;
        8'h70: hit_b[0] = 1'b1;
        8'h69: hit_b[1] = 1'b1;
        8'h72: hit_b[2] = 1'b1;
        8'h7A: hit_b[3] = 1'b1;
        8'h6B: hit_b[4] = 1'b1;
        8'h73: hit_b[5] = 1'b1;
        8'h74: hit_b[6] = 1'b1;
        8'h6C: hit_b[7] = 1'b1;
        8'h75: hit_b[8] = 1'b1;
        8'h7D: hit_b[9] = 1'b1;
        default: ;
      endcase
    end
  end

  // Toggle tracking; first clock after reset only samples the level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgl_q  <= 1'b0;
      primed <= 1'b0;
    end else begin
      tgl_q  <= kp.ps2_key[10];
      primed <= 1'b1;
    end
  end

  // Per-key down bit and saturating hold counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      down <= '0;
      for (int i = 0; i < 20; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 20; i++) begin
        if (ev && hit[i] && press) begin
          down[i] <= 1'b1;
          cnt[i]  <= HOLD;
        end else begin
          if (ev && hit[i]) down[i] <= 1'b0;
          if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

  // A key reads active while held or while its hold is running
  always_comb begin
    active = '0;
    for (int i = 0; i < 20; i++) active[i] = down[i] | (cnt[i] != '0);
  end

  assign sel_3 = kp.swap ? {6'b0, keys_b_q} : {6'b0, keys_a_q};
  assign sel_4 = kp.swap ? {6'b0, keys_a_q} : {6'b0, keys_b_q};

  // Registered masks, then the CPU-selected scan flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_a_q <= '0;
      keys_b_q <= '0;
      ef3_q    <= 1'b0;
      ef4_q    <= 1'b0;
    end else begin
      keys_a_q <= active[9:0];
      keys_b_q <= active[19:10];
      ef3_q    <= (kp.key_sel < 4'd10) && sel_3[kp.key_sel];
      ef4_q    <= (kp.key_sel < 4'd10) && sel_4[kp.key_sel];
    end
  end

  assign kp.keys_a = keys_a_q;
  assign kp.keys_b = keys_b_q;
  assign kp.ef3    = ef3_q;
  assign kp.ef4    = ef4_q;

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad with a short hold
// (HOLD_CYCLES=8) and hand-computed expectations.
module tb_studio2_keypad;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  studio2_keypad_if kp ();

  studio2_keypad #(.HOLD_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic pr, input logic ext,
                      input logic [7:0] sc);
    kp.ps2_key = {~kp.ps2_key[10], pr, ext, sc};
  endtask

  int c_ef;
  int c_kb;
  logic any;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    kp.ps2_key = 11'h400;
    kp.swap    = 1'b0;
    kp.key_sel = 4'd0;
    tick(2);
    check("rst_keys_a", 32'(kp.keys_a), 0);
    check("rst_ef", {30'b0, kp.ef3, kp.ef4}, 0);

    // 1: reset release with toggle high
    reset_n = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any |= kp.ef3 | kp.ef4 | (|kp.keys_a) | (|kp.keys_b);
    end
    check("s1_quiet", 32'(any), 0);

    // 1b: stale toggle carrying a mapped press code
    reset_n = 1'b0;
    kp.ps2_key = 11'h645;
    tick();
    reset_n = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any |= (|kp.keys_a) | kp.ef3;
    end
    check("s1_no_phantom", 32'(any), 0);

    // 2: pad A key 3 press, held, then released
    kp.key_sel = 4'd3;
    send(1'b1, 1'b0, 8'h26);
    tick(2);
    check("s2_keys_a", 32'(kp.keys_a), 32'h008);
    check("s2_ef3_early", 32'(kp.ef3), 0);
    tick();
    check("s2_ef3_on", 32'(kp.ef3), 1);
    tick(17);
    send(1'b0, 1'b0, 8'h26);
    tick(2);
    check("s2_ef3_hold", 32'(kp.ef3), 1);
    check("s2_keys_a_off", 32'(kp.keys_a), 0);
    tick();
    check("s2_ef3_off", 32'(kp.ef3), 0);

    // 3: short tap on pad B key 9
    kp.key_sel = 4'd9;
    c_ef = 0;
    c_kb = 0;
    send(1'b1, 1'b0, 8'h7D);
    tick();
    send(1'b0, 1'b0, 8'h7D);
    for (int i = 0; i < 30; i++) begin
      tick();
      c_ef += int'(kp.ef4);
      c_kb += int'(kp.keys_b[9]);
    end
    check("s3_ef4_cycles", 32'(c_ef), 8);
    check("s3_keys_b9_cycles", 32'(c_kb), 8);

    // 4: extended and unmapped codes
    send(1'b1, 1'b1, 8'h70);
    tick(3);
    send(1'b1, 1'b0, 8'h1C);
    tick(3);
    check("s4_keys_a", 32'(kp.keys_a), 0);
    check("s4_keys_b", 32'(kp.keys_b), 0);

    // 5: multi-key, swap, out-of-range select
    kp.key_sel = 4'd5;
    send(1'b1, 1'b0, 8'h2E);
    tick();
    send(1'b1, 1'b0, 8'h73);
    tick();
    send(1'b0, 1'b0, 8'h73);
    tick(12);
    check("s5_keys_a", 32'(kp.keys_a), 32'h020);
    check("s5_keys_b", 32'(kp.keys_b), 0);
    check("s5_ef3", 32'(kp.ef3), 1);
    check("s5_ef4", 32'(kp.ef4), 0);
    kp.swap = 1'b1;
    tick();
    check("s5_swap_ef3", 32'(kp.ef3), 0);
    check("s5_swap_ef4", 32'(kp.ef4), 1);
    kp.key_sel = 4'd12;
    tick();
    check("s5_sel12", {30'b0, kp.ef3, kp.ef4}, 0);

    // 6: reset during a hold with cnt=5
    kp.swap    = 1'b0;
    kp.key_sel = 4'd5;
    send(1'b1, 1'b0, 8'h2E);
    tick(4);
    check("s6_pre_ef3", 32'(kp.ef3), 1);
    reset_n = 1'b0;
    #1;
    check("s6_async_keys_a", 32'(kp.keys_a), 0);
    check("s6_async_ef3", 32'(kp.ef3), 0);
    tick(2);
    reset_n = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any |= (|kp.keys_a) | kp.ef3;
    end
    check("s6_stays_off", 32'(any), 0);
    send(1'b1, 1'b0, 8'h2E);
    tick(3);
    check("s6_new_press", 32'(kp.ef3), 1);
    check("s6_new_keys_a", 32'(kp.keys_a), 32'h020);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
